// File: rtl/phase_pkg.sv
// Shared constants, LFSR helper and tuning-word FSM states for the phase accumulator slice.
package phase_pkg;

    localparam int unsigned ACC_W_DEF  = 24;
    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DIV_W_DEF  = 16;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        TW_IDLE,
        TW_PENDING
    } tw_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/phase_accumulator_if.sv
// Tuning-word handshake and phase output bundle between a controller and the phase accumulator.
interface phase_accumulator_if
    import phase_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [ACC_W-1:0]  tw_data;
    logic              tw_valid;
    logic              tw_ready;
    logic [ADDR_W-1:0] phase_addr;
    logic              phase_valid;
    logic              cycle_wrap;

    modport master (
        output tw_data,
        output tw_valid,
        input  tw_ready,
        input  phase_addr,
        input  phase_valid,
        input  cycle_wrap
    );

    modport slave (
        input  tw_data,
        input  tw_valid,
        output tw_ready,
        output phase_addr,
        output phase_valid,
        output cycle_wrap
    );

endinterface

// File: rtl/tick_divider.sv
// Sample-rate divider: counts 0..div and fires tick whenever the count has reached div.
module tick_divider
    import phase_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // >= rather than == so lowering div below the running count still fires promptly.
    assign tick = (count >= div);

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/phase_accumulator.sv
// NCO phase source: accumulates the active tuning word per tick and emits the truncated address.
// Optional build macro PHASE_DITHER_EN adds LFSR dither to the truncation only.
module phase_accumulator
    import phase_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div,
    phase_accumulator_if.slave bus
);

    logic tick;

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .div  (div),
        .tick (tick)
    );

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  tw_active;
    logic [ACC_W-1:0]  tw_pending;
    logic [ACC_W:0]    sum;
    logic              carry;
    logic [ADDR_W-1:0] addr_nxt;

    logic [ADDR_W-1:0] phase_addr_q;
    logic              phase_valid_q;
    logic              cycle_wrap_q;
    logic              tw_ready_q;

    tw_state_e state;
    tw_state_e state_nxt;
    logic      accept;
    logic      apply;

    assign sum   = {1'b0, acc} + {1'b0, tw_active};
    assign carry = sum[ACC_W];

    // tw_ready_q is only high in IDLE, so accept implies an IDLE capture.
    assign accept = bus.tw_valid && tw_ready_q;

`ifdef PHASE_DITHER_EN
    localparam int DITH_W = ACC_W - ADDR_W;

    if (DITH_W > 16 || DITH_W < 1) begin : g_dither_width_check
        $error("phase_accumulator: ACC_W-ADDR_W must be in 1..16 for dithering");
    end

    logic [15:0]      lfsr;
    logic [ACC_W-1:0] dithered;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (tick) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Dither only perturbs the truncation; acc and the carry stay clean.
    assign dithered = sum[ACC_W-1:0] + ACC_W'(lfsr[DITH_W-1:0]);
    assign addr_nxt = dithered[ACC_W-1 -: ADDR_W];
`else
    assign addr_nxt = sum[ACC_W-1 -: ADDR_W];
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        unique case (state)
            TW_IDLE: begin
                if (accept) begin
                    state_nxt = TW_PENDING;
                end
            end
            TW_PENDING: begin
                // A stopped generator never wraps, so load it straight away.
                if (tw_active == '0 || (tick && carry)) begin
                    apply     = 1'b1;
                    state_nxt = TW_IDLE;
                end
            end
            default: begin
                state_nxt = TW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= TW_IDLE;
            acc           <= '0;
            tw_active     <= '0;
            tw_pending    <= '0;
            tw_ready_q    <= 1'b0;
            phase_addr_q  <= '0;
            phase_valid_q <= 1'b0;
            cycle_wrap_q  <= 1'b0;
        end else begin
            state         <= state_nxt;
            tw_ready_q    <= (state_nxt == TW_IDLE);
            phase_valid_q <= tick;
            cycle_wrap_q  <= tick && carry;

            if (accept) begin
                tw_pending <= bus.tw_data;
            end

            // The wrapping add itself used the old word; the new one counts from the next tick.
            if (apply) begin
                tw_active <= tw_pending;
            end

            if (tick) begin
                acc          <= sum[ACC_W-1:0];
                phase_addr_q <= addr_nxt;
            end
        end
    end

    assign bus.tw_ready    = tw_ready_q;
    assign bus.phase_addr  = phase_addr_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.cycle_wrap  = cycle_wrap_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed self-checking bench for phase_accumulator: table of divider/tuning vectors plus wrap and reset sequences.
module tb_phase_accumulator;
    import phase_pkg::*;

    localparam int ACC_W  = 24;
    localparam int ADDR_W = 9;
    localparam int DIV_W  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] div = '0;

    phase_accumulator_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    phase_accumulator #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .div (div),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [DIV_W-1:0]  div;
        logic [ACC_W-1:0]  tw;
        int                gap;
        logic [ADDR_W-1:0] delta;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic check_addr(input string name, input logic [ADDR_W-1:0] exp);
        logic [ADDR_W-1:0] act;
        logic [ADDR_W-1:0] diff;
        bit                ok;
        act  = bus.phase_addr;
        diff = act - exp;
`ifdef PHASE_DITHER_EN
        ok = (diff == '0) || (diff == ADDR_W'(1)) || (diff == '1);
`else
        ok = (act === exp);
`endif
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic do_reset(input logic [DIV_W-1:0] d);
        rst          = 1'b1;
        bus.tw_valid = 1'b0;
        div          = d;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        for (int k = 0; k < 2000 && bus.tw_ready !== 1'b1; k++) @(negedge clk);
        check(name, bus.tw_ready, 1);
    endtask

    task automatic load_word(input logic [ACC_W-1:0] tw);
        wait_ready("ready_before_load");
        bus.tw_data  = tw;
        bus.tw_valid = 1'b1;
        @(negedge clk);
        bus.tw_valid = 1'b0;
        check("ready_drop", bus.tw_ready, 0);
        wait_ready("ready_after_load");
    endtask

    task automatic wait_strobe(input string name);
        for (int k = 0; k < 100 && bus.phase_valid !== 1'b1; k++) @(negedge clk);
        check(name, bus.phase_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.tw_valid = 1'b0;
        bus.tw_data  = '0;

        //          div     tw            gap over 4 strobes, addr delta over 4 strobes
        vecs[0] = '{16'd0, 24'd32768,   4, 9'd4};
        vecs[1] = '{16'd3, 24'd32768,  16, 9'd4};
        vecs[2] = '{16'd1, 24'd65536,   8, 9'd8};
        vecs[3] = '{16'd7, 24'd98304,  32, 9'd12};
        vecs[4] = '{16'd2, 24'd0,      12, 9'd0};
        vecs[5] = '{16'd0, 24'd16384,   4, 9'd2};
        vecs[6] = '{16'd4, 24'h800000, 20, 9'd0};

        // Reset state while rst is held, then ready on the first cycle after release.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.tw_ready, 0);
        check("rst_valid", bus.phase_valid, 0);
        check("rst_addr", bus.phase_addr, 0);
        check("rst_wrap", bus.cycle_wrap, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", bus.tw_ready, 1);

        for (int i = 0; i < 7; i++) begin
            int                cyc;
            int                n;
            logic [ADDR_W-1:0] a0;
            do_reset(vecs[i].div);
            load_word(vecs[i].tw);
            wait_strobe($sformatf("v%0d_first_strobe", i));
            a0  = bus.phase_addr;
            cyc = 0;
            n   = 0;
            while (n < 4 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (bus.phase_valid === 1'b1) n++;
            end
            check($sformatf("v%0d_gap", i), cyc, vecs[i].gap);
`ifndef PHASE_DITHER_EN
            check($sformatf("v%0d_delta", i), ADDR_W'(bus.phase_addr - a0), vecs[i].delta);
`endif
        end

        // Full ramp at one address step per cycle, wrap exactly on the 512th tick.
        do_reset(16'd0);
        load_word(24'd32768);
        check_addr("ramp_start", 9'd0);
        for (int k = 1; k <= 512; k++) begin
            @(negedge clk);
            check_addr("ramp_addr", ADDR_W'(k));
            check("ramp_valid", bus.phase_valid, 1);
            check("ramp_wrap", bus.cycle_wrap, (k == 512));
        end

        // Frequency change requested at address 100 waits for the wrap.
        repeat (100) @(negedge clk);
        check_addr("chg_at_100", 9'd100);
        check("chg_ready_idle", bus.tw_ready, 1);
        bus.tw_data  = 24'd65536;
        bus.tw_valid = 1'b1;
        @(negedge clk);
        bus.tw_valid = 1'b0;
        check("chg_ready_drop", bus.tw_ready, 0);
        check_addr("chg_addr_101", 9'd101);
        for (int k = 102; k <= 511; k++) begin
            @(negedge clk);
            check_addr("chg_old_step", ADDR_W'(k));
            check("chg_ready_low", bus.tw_ready, 0);
        end
        @(negedge clk);
        check_addr("chg_wrap_addr", 9'd0);
        check("chg_wrap", bus.cycle_wrap, 1);
        check("chg_ready_back", bus.tw_ready, 1);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check_addr("chg_new_step", ADDR_W'(2 * j));
        end

        // Handshake on the wrapping tick is held for a full further cycle.
        do_reset(16'd0);
        load_word(24'd32768);
        repeat (511) @(negedge clk);
        check_addr("coin_at_511", 9'd511);
        bus.tw_data  = 24'd65536;
        bus.tw_valid = 1'b1;
        @(negedge clk);
        bus.tw_valid = 1'b0;
        check_addr("coin_wrap_addr", 9'd0);
        check("coin_wrap", bus.cycle_wrap, 1);
        check("coin_ready_low", bus.tw_ready, 0);
        for (int k = 1; k <= 511; k++) begin
            @(negedge clk);
            check_addr("coin_old_step", ADDR_W'(k));
            check("coin_still_pending", bus.tw_ready, 0);
        end
        @(negedge clk);
        check_addr("coin_wrap2_addr", 9'd0);
        check("coin_wrap2", bus.cycle_wrap, 1);
        check("coin_ready_back", bus.tw_ready, 1);
        @(negedge clk);
        check_addr("coin_new_step", 9'd2);

        // Mid-run reset with a word pending discards it.
        check("rstmid_ready_idle", bus.tw_ready, 1);
        bus.tw_data  = 24'd98304;
        bus.tw_valid = 1'b1;
        @(negedge clk);
        bus.tw_valid = 1'b0;
        check("rstmid_pending", bus.tw_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_addr", bus.phase_addr, 0);
        check("rstmid_valid", bus.phase_valid, 0);
        check("rstmid_wrap", bus.cycle_wrap, 0);
        check("rstmid_ready", bus.tw_ready, 0);
        @(negedge clk);
        check("rstmid_ready_rise", bus.tw_ready, 1);
        repeat (5) @(negedge clk);
        check("rstmid_word_lost", bus.phase_addr, 0);
        check("rstmid_ticking", bus.phase_valid, 1);

        // Lowering div below the running count fires the tick on the next cycle.
        do_reset(16'd9);
        load_word(24'd32768);
        wait_strobe("divlow_strobe");
        repeat (5) @(negedge clk);
        check("divlow_quiet", bus.phase_valid, 0);
        div = 16'd2;
        @(negedge clk);
        check("divlow_tick", bus.phase_valid, 1);
        begin
            int cyc;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (bus.phase_valid !== 1'b1 && cyc < 50);
            check("divlow_new_period", cyc, 3);
        end

`ifdef PHASE_DITHER_EN
        // Dither leaves the undithered wrap period intact.
        do_reset(16'd0);
        load_word(24'd32768);
        begin
            int cyc;
            cyc = 0;
            while (bus.cycle_wrap !== 1'b1 && cyc < 1000) begin
                @(negedge clk);
                cyc++;
            end
            check("dith_first_wrap", bus.cycle_wrap, 1);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (bus.cycle_wrap !== 1'b1 && cyc < 1000);
            check("dith_wrap_period", cyc, 512);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/phase_accumulator.md
# phase_accumulator

Numerically controlled phase source that drives the quarter-wave sine lookup stage. It replaces that stage's free-running address counter with a programmable-frequency phase. A wide accumulator advances by a tuning word on each sample tick, and each tick's truncated upper bits are presented as the 9-bit lookup address. New tuning words are accepted over a valid/ready handshake and take effect only at a phase wrap, so frequency changes never glitch the waveform.

## Interface
Parameters:
- ACC_W, 24: accumulator width.
- ADDR_W, 9: output phase address width. Must match the lookup stage's full-cycle address.
- DIV_W, 16: sample-rate divider width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset. Synchronous and active-high.
- tw_data  in  ACC_W  requested tuning word (phase increment per tick).
- tw_valid  in  1  tw_data is valid.
- tw_ready  out  1  block can accept a tuning word.
- div  in  DIV_W  tick period minus one; sampled every cycle.
- phase_addr  out  ADDR_W  lookup address (registered).
- phase_valid  out  1  one-cycle strobe: phase_addr is updated this cycle.
- cycle_wrap  out  1  one-cycle strobe, coincident with the phase_valid whose update carried out of the accumulator.

## Operation
- **Tick generation**
  - The divider counter counts 0..div. The tick fires when count >= div, and count then returns to 0.
  - div = 0 gives a tick every cycle.
  - If div is lowered below the current count, the tick fires on the next cycle.
- **Accumulator update**
  - On each tick: acc <= acc + tw_active, modulo 2^ACC_W.
  - The carry-out of that add sets cycle_wrap.
- **Address output**
  - phase_addr = acc[ACC_W-1 -: ADDR_W], or the dithered form described under Configuration.
- **Tuning-word FSM**
  - IDLE: tw_ready=1. When tw_valid && tw_ready, capture tw_data into tw_pending and go to PENDING.
  - PENDING: tw_ready=0. On a tick whose add carries out, the add uses the old tw_active. tw_active <= tw_pending takes effect from the next tick. Return to IDLE.
  - PENDING with tw_active == 0 (generator stopped): apply tw_pending on the next cycle without waiting for a wrap, and return to IDLE.
- **Boundaries**
  - A handshake on the same cycle as a wrapping tick is captured into PENDING and waits for the next wrap. It is not applied on that wrap.
  - tw_data = 0 is legal: the accumulator holds its value, and phase_valid still strobes on each tick with an unchanged address.
- **Reset values**
  - acc=0, tw_active=0, tw_pending=0, divider count=0, FSM=IDLE.
  - phase_addr=0, phase_valid=0, cycle_wrap=0.
  - tw_ready=0 while rst is high and 1 on the first cycle after rst falls.
  - Asserting rst mid-operation discards any pending word.

## Timing
- Tick condition in cycle N: acc, phase_addr, phase_valid and cycle_wrap are all registered and visible in cycle N+1.
- The downstream lookup adds its own 1-cycle memory latency.
- Tuning-word latency: applied on the first wrapping tick after capture, or 1 cycle after capture when tw_active==0.
- tw_ready falls the cycle after an accepted handshake. tw_ready rises the cycle after the tuning word is applied.
- No combinational path from any input to any output.

## Configuration
- PHASE_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) seeds to 16'hACE1 on rst and advances on each tick.
  - Its low ACC_W-ADDR_W bits are added to acc only for the truncation: phase_addr = (acc + dither)[ACC_W-1 -: ADDR_W], modulo 2^ADDR_W.
  - The dither is never fed back into acc. cycle_wrap still reflects the undithered carry.
  - Requires ACC_W-ADDR_W <= 16; this is checked with an elaboration-time assertion.
- PHASE_DITHER_EN undefined: no LFSR is instantiated, and phase_addr is plain truncation.

## Structure
- Package phase_pkg holds:
  - default ACC_W, ADDR_W and DIV_W constants;
  - the LFSR seed and tap mask;
  - the tuning-word FSM state enum (TW_IDLE, TW_PENDING).
- Sub-module tick_divider (clk, rst, div, tick) owns the divider counter. All accumulator, FSM and dither logic stays in phase_accumulator.

## Test plan
- Load tw=32768 (2^15) after reset with div=0 (load is immediate since tw_active=0):
  - phase_addr steps 0,1,2…511,0 on consecutive cycles;
  - cycle_wrap is high only with the phase_valid that shows 0, after 512 ticks.
- div=3, tw=32768: phase_valid every 4th cycle; phase_addr advances by 1 per strobe.
- Running tw=32768, send tw=65536 at phase_addr=100:
  - tw_ready drops;
  - steps of 1 continue to the wrap;
  - after the wrap, steps of 2 (0,2,4…);
  - tw_ready returns high.
- Handshake coincident with a wrapping tick: the word is not applied until the following wrap, 512 ticks later at tw=32768.
- Assert rst for 1 cycle mid-run with a word pending:
  - the next cycle shows phase_addr=0, phase_valid=0, cycle_wrap=0, tw_ready=0;
  - tw_ready=1 on the cycle after that;
  - the pending word is lost (acc stays 0).
- With PHASE_DITHER_EN, tw=32768:
  - cycle_wrap period stays at exactly 512 ticks;
  - |phase_addr - undithered address| <= 1 (mod 512) on every sample.
